// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if: link between the capture controller and the adc_capture core.
// The master side (controller) drives the run/hold control and the slot configs.
// It observes the core's RAM write address and write strobe.
interface adc_capture_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              adc_start;
   logic              adc_sequence_one;
   logic [31:0]       adc_config_odd;
   logic [31:0]       adc_config_even;
   logic [ADDR_W-1:0] adc_ram_addr;
   logic              adc_ram_we;

   modport master (
      output adc_start,
      output adc_sequence_one,
      output adc_config_odd,
      output adc_config_even,
      input  adc_ram_addr,
      input  adc_ram_we
   );

   modport slave (
      input  adc_start,
      input  adc_sequence_one,
      input  adc_config_odd,
      input  adc_config_even,
      output adc_ram_addr,
      output adc_ram_we
   );
endinterface

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: sequences one capture run of adc_capture (load, arm, run, drain).
// It also tracks filled half-buffers against host acknowledgements.
// Optional watchdog: define ADC_CAPTURE_CTRL_WATCHDOG_EN to abort a run whose RAM writes stop.
// Without the macro, stall is tied low and no watchdog logic is built.
module adc_capture_ctrl #(
   parameter int ADDR_W       = 12,
   parameter int ARM_CYCLES   = 13,
   parameter int DRAIN_CYCLES = 8,
   parameter int WDT_CYCLES   = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        host_start,
   input  logic        host_stop,
   input  logic [15:0] host_frames,
   input  logic        host_single,
   input  logic [31:0] host_cfg_odd,
   input  logic [31:0] host_cfg_even,
   input  logic        host_ack,
   adc_capture_ctrl_if.master cap,
   output logic        busy,
   output logic        half_ready,
   output logic        half_sel,
   output logic        done,
   output logic        overrun,
   output logic        stall
);
   // One counter width serves the arm/drain phase counter and the watchdog.
   localparam int PHASE_MAX = (ARM_CYCLES > DRAIN_CYCLES) ? ARM_CYCLES : DRAIN_CYCLES;
   localparam int CNT_MAX   = (PHASE_MAX > WDT_CYCLES) ? PHASE_MAX : WDT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] phase_cnt;
   logic [15:0]      frame_cnt;
   logic             frame_limited;
   logic [1:0]       pending;
   logic             completion;
   logic             frames_exhausted;
   logic             arm_last;
   logic             drain_last;
   logic             wdt_hit;
   logic             adc_start_c;

   // The last address of either half (all low bits set) marks that half as full.
   // This is only counted while running.
   assign completion       = (state == RUN) && cap.adc_ram_we && (&cap.adc_ram_addr[ADDR_W-2:0]);
   assign frames_exhausted = frame_limited && (frame_cnt == 16'd0);
   assign arm_last         = (phase_cnt == CNT_W'(ARM_CYCLES - 1));
   assign drain_last       = (phase_cnt == CNT_W'(DRAIN_CYCLES - 1));
   assign cap.adc_start    = adc_start_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   // The core is held (adc_start high) everywhere except RUN.
   always_comb begin
      state_nx    = state;
      adc_start_c = 1'b1;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (host_start && !host_stop) state_nx = LOAD;
         end
         LOAD:  state_nx = ARM;
         ARM: begin
            if (host_stop)     state_nx = DRAIN;
            else if (arm_last) state_nx = RUN;
         end
         RUN: begin
            adc_start_c = 1'b0;
            if (host_stop || frames_exhausted || wdt_hit) state_nx = DRAIN;
         end
         DRAIN: if (drain_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Phase counter: restarts on every state change and measures the arm and drain hold times.
   always_ff @(posedge clk) begin
      if (rst)                                 phase_cnt <= '0;
      else if (state_nx != state)              phase_cnt <= '0;
      else if (state == ARM || state == DRAIN) phase_cnt <= phase_cnt + 1'b1;
   end

   // Run configuration: captured once in LOAD and held steady for the whole run.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap.adc_config_odd   <= '0;
         cap.adc_config_even  <= '0;
         cap.adc_sequence_one <= 1'b0;
      end else if (state == LOAD) begin
         cap.adc_config_odd   <= host_cfg_odd;
         cap.adc_config_even  <= host_cfg_even;
         cap.adc_sequence_one <= host_single;
      end
   end

   // Frame budget: zero at load means continuous capture, otherwise count down per completed half.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt     <= '0;
         frame_limited <= 1'b0;
      end else if (state == LOAD) begin
         frame_cnt     <= host_frames;
         frame_limited <= (host_frames != 16'd0);
      end else if (completion && frame_limited && frame_cnt != 16'd0) begin
         frame_cnt <= frame_cnt - 16'd1;
      end
   end

   // Half-buffer notification: one-cycle pulse after the completing write, tagged with which half.
   always_ff @(posedge clk) begin
      if (rst) begin
         half_ready <= 1'b0;
         half_sel   <= 1'b0;
      end else begin
         half_ready <= completion;
         if (completion) half_sel <= cap.adc_ram_addr[ADDR_W-1];
      end
   end

   // Host backlog: at most two unacknowledged halves.
   // A third full half while two are pending means the host fell behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 2'd0;
         overrun <= 1'b0;
      end else if (state == LOAD) begin
         pending <= 2'd0;
         overrun <= 1'b0;
      end else begin
         case ({half_ready, host_ack})
            2'b10: begin
               if (pending == 2'd2) overrun <= 1'b1;
               else                 pending <= pending + 2'd1;
            end
            2'b01: if (pending != 2'd0) pending <= pending - 2'd1;
            default: ;
         endcase
      end
   end

   // End-of-run pulse, raised on the way out of DRAIN.
   always_ff @(posedge clk) begin
      if (rst) done <= 1'b0;
      else     done <= (state == DRAIN) && drain_last;
   end

`ifdef ADC_CAPTURE_CTRL_WATCHDOG_EN
   logic [CNT_W-1:0] wdt_cnt;

   assign wdt_hit = (state == RUN) && !cap.adc_ram_we && (wdt_cnt == CNT_W'(WDT_CYCLES - 1));

   // Watchdog: counts RUN cycles since the last RAM write; expiry flags a stall and ends the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt <= '0;
         stall   <= 1'b0;
      end else if (state == LOAD) begin
         wdt_cnt <= '0;
         stall   <= 1'b0;
      end else if (state == RUN) begin
         if (cap.adc_ram_we) wdt_cnt <= '0;
         else                wdt_cnt <= wdt_cnt + 1'b1;
         if (wdt_hit) stall <= 1'b1;
      end else begin
         wdt_cnt <= '0;
      end
   end
`else
   assign wdt_hit = 1'b0;
   assign stall   = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed, table-driven bench for adc_capture_ctrl at default parameters.
module tb_adc_capture_ctrl;
   localparam int ADDR_W = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_start;
   logic        host_stop;
   logic [15:0] host_frames;
   logic        host_single;
   logic [31:0] host_cfg_odd;
   logic [31:0] host_cfg_even;
   logic        host_ack;
   logic        busy;
   logic        half_ready;
   logic        half_sel;
   logic        done;
   logic        overrun;
   logic        stall;

   int compare_count = 0;
   int fail_count    = 0;

   adc_capture_ctrl_if #(.ADDR_W(ADDR_W)) cap_if ();

   adc_capture_ctrl #(
      .ADDR_W(ADDR_W), .ARM_CYCLES(13), .DRAIN_CYCLES(8), .WDT_CYCLES(1024)
   ) dut (
      .clk(clk), .rst(rst),
      .host_start(host_start), .host_stop(host_stop), .host_frames(host_frames),
      .host_single(host_single), .host_cfg_odd(host_cfg_odd), .host_cfg_even(host_cfg_even),
      .host_ack(host_ack), .cap(cap_if),
      .busy(busy), .half_ready(half_ready), .half_sel(half_sel),
      .done(done), .overrun(overrun), .stall(stall)
   );

   // 100 MHz bench clock; the DUT timing is cycle-based so the exact rate is irrelevant.
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic        ack;
      logic        stop;
      logic        exp_start;
      logic        exp_busy;
      logic        exp_hr;
      logic        exp_hs;
      logic        exp_ovr;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, clock it in, then release the pulse inputs.
   task automatic apply_stimulus(input logic start, input logic stop, input logic we,
                                 input logic [11:0] addr, input logic ack);
      host_start          = start;
      host_stop           = stop;
      cap_if.adc_ram_we   = we;
      cap_if.adc_ram_addr = addr;
      host_ack            = ack;
      tick();
      host_start        = 1'b0;
      host_stop         = 1'b0;
      cap_if.adc_ram_we = 1'b0;
      host_ack          = 1'b0;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compare_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Start a run and wait (bounded) until the core is released into RUN.
   task automatic start_run(input logic [15:0] frames);
      int n;
      host_frames = frames;
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
      n = 0;
      while (cap_if.adc_start && n < 100) begin
         n++;
         tick();
      end
      check_output("reach_run", {31'd0, cap_if.adc_start}, 32'd0);
   endtask

   // Count drain cycles (core held, still busy) until the run ends, then verify the done pulse.
   task automatic check_drain(input string tag);
      int n;
      n = 0;
      while (cap_if.adc_start && busy && n < 100) begin
         n++;
         tick();
      end
      check_output({tag, "_drain_cycles"}, n, 32'd8);
      check_output({tag, "_done"}, {31'd0, done}, 32'd1);
      check_output({tag, "_idle"}, {31'd0, busy}, 32'd0);
      tick();
      check_output({tag, "_done_one_pulse"}, {31'd0, done}, 32'd0);
   endtask

   // Safety net so the bench can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int   n;
      logic saw_done;

      // Continuous-run table: expected outputs after each cycle's edge.
      //           we    addr      ack   stop  start busy  hr    hs    ovr
      vecs[0] = '{1'b1, 12'd2047, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 12'd2047, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 12'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 12'd100,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 12'd2047, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 12'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 12'd0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 12'd0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      host_start = 1'b0; host_stop = 1'b0; host_frames = 16'd0; host_ack = 1'b0;
      host_single = 1'b1; host_cfg_odd = 32'hDEAD_BEEF; host_cfg_even = 32'h1234_5678;
      cap_if.adc_ram_addr = '0; cap_if.adc_ram_we = 1'b0;

      // Reset dominates noisy inputs.
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b1, 12'd2047, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 12'd4095, 1'b0);
      check_output("rst_adc_start", {31'd0, cap_if.adc_start}, 32'd1);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_seq_one", {31'd0, cap_if.adc_sequence_one}, 32'd0);
      check_output("rst_cfg_odd", cap_if.adc_config_odd, 32'd0);
      check_output("rst_cfg_even", cap_if.adc_config_even, 32'd0);
      check_output("rst_half_ready", {31'd0, half_ready}, 32'd0);
      check_output("rst_half_sel", {31'd0, half_sel}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_overrun", {31'd0, overrun}, 32'd0);
      check_output("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;

      // IDLE: start together with stop is refused; writes are ignored.
      apply_stimulus(1'b1, 1'b1, 1'b0, 12'd0, 1'b0);
      check_output("idle_start_stop", {31'd0, busy}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd2047, 1'b0);
      check_output("idle_write_ignored", {31'd0, half_ready}, 32'd0);

      // Run 1: two frames, arm length, config capture, completions, drain.
      host_frames = 16'd2; host_cfg_odd = 32'hA5A5_0001; host_cfg_even = 32'h5A5A_0002; host_single = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
      check_output("load_busy", {31'd0, busy}, 32'd1);
      tick();
      check_output("cfg_odd_latched", cap_if.adc_config_odd, 32'hA5A5_0001);
      check_output("cfg_even_latched", cap_if.adc_config_even, 32'h5A5A_0002);
      check_output("seq_one_latched", {31'd0, cap_if.adc_sequence_one}, 32'd1);
      host_cfg_odd = 32'h0BAD_0BAD; host_cfg_even = 32'hFFFF_FFFF; host_single = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd2047, 1'b0);
      check_output("arm_write_ignored", {31'd0, half_ready}, 32'd0);
      n = 1;
      while (cap_if.adc_start && n < 100) begin
         n++;
         tick();
      end
      check_output("arm_cycles", n, 32'd13);
      check_output("cfg_odd_held", cap_if.adc_config_odd, 32'hA5A5_0001);
      check_output("seq_one_held", {31'd0, cap_if.adc_sequence_one}, 32'd1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd2047, 1'b0);
      check_output("run1_hr_lower", {31'd0, half_ready}, 32'd1);
      check_output("run1_sel_lower", {31'd0, half_sel}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
      check_output("run1_hr_pulse", {31'd0, half_ready}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 12'd4095, 1'b0);
      check_output("run1_hr_upper", {31'd0, half_ready}, 32'd1);
      check_output("run1_sel_upper", {31'd0, half_sel}, 32'd1);
      check_output("run_start_ignored", {31'd0, cap_if.adc_start}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1);
      check_output("frames_to_drain", {31'd0, cap_if.adc_start}, 32'd1);
      check_drain("run1");
      check_output("run1_overrun", {31'd0, overrun}, 32'd0);

      // Stop while arming goes straight to drain.
      host_frames = 16'd0;
      apply_stimulus(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
      check_drain("arm_stop");

      // Run 2: continuous capture driven from the table, ended by host_stop.
      start_run(16'd0);
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b0, vecs[i].stop, vecs[i].we, vecs[i].addr, vecs[i].ack);
         check_output($sformatf("vec%0d_adc_start", i), {31'd0, cap_if.adc_start}, {31'd0, vecs[i].exp_start});
         check_output($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
         check_output($sformatf("vec%0d_half_ready", i), {31'd0, half_ready}, {31'd0, vecs[i].exp_hr});
         check_output($sformatf("vec%0d_half_sel", i), {31'd0, half_sel}, {31'd0, vecs[i].exp_hs});
         check_output($sformatf("vec%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
      end
      check_drain("run2");

      // Run 3: completion coinciding with an ack at pending=1 leaves pending at 1.
      start_run(16'd0);
      check_output("load_clears_overrun", {31'd0, overrun}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd2047, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd4095, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd2047, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
      check_output("coincident_no_overrun", {31'd0, overrun}, 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd4095, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
      check_output("coincident_then_overrun", {31'd0, overrun}, 32'd1);

      // Reset in the middle of RUN: back to IDLE at once, no done pulse.
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b1, 12'd100, 1'b0);
      rst = 1'b0;
      check_output("midrun_rst_busy", {31'd0, busy}, 32'd0);
      check_output("midrun_rst_adc_start", {31'd0, cap_if.adc_start}, 32'd1);
      check_output("midrun_rst_overrun", {31'd0, overrun}, 32'd0);
      saw_done = done;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_done = saw_done | done;
      end
      check_output("midrun_rst_no_done", {31'd0, saw_done}, 32'd0);

      // Run 4: no RAM writes for a long stretch of RUN.
      start_run(16'd0);
      n = 0;
      while (!cap_if.adc_start && n < 1100) begin
         n++;
         tick();
      end
`ifdef ADC_CAPTURE_CTRL_WATCHDOG_EN
      check_output("wdt_run_cycles", n, 32'd1024);
      check_output("wdt_stall", {31'd0, stall}, 32'd1);
      check_drain("wdt");
`else
      check_output("no_wdt_still_run", n, 32'd1100);
      check_output("no_wdt_stall", {31'd0, stall}, 32'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
      check_drain("no_wdt");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end
endmodule
